// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin bundle plus debounced key outputs.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scan_ctrl_if #(
   parameter int ROWS = 4,
   parameter int COLS = 3
) ();
   localparam int CODE_W = $clog2(ROWS * COLS);

   logic [ROWS-1:0]   touch_key;
   logic [COLS-1:0]   scan_key;
   logic [CODE_W-1:0] key_code;
   logic              key_down;
   logic              key_valid;
   logic              key_release;

   modport master (
      input  touch_key,
      output scan_key,
      output key_code,
      output key_down,
      output key_valid,
      output key_release
   );

   modport slave (
      output touch_key,
      input  scan_key,
      input  key_code,
      input  key_down,
      input  key_valid,
      input  key_release
   );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: column strobe, frame debounce,
// press/release events and optional auto-repeat.
module keypad_scan_ctrl #(
   parameter int COLS          = 3,
   parameter int ROWS          = 4,
   parameter int SCAN_DIV      = 50000,
   parameter int DEB_FRAMES    = 3,
   parameter int REPEAT_FRAMES = 0
) (
   input  logic                 fin,
   input  logic                 rst,
   keypad_scan_ctrl_if.master   kp
);
   localparam int N      = ROWS * COLS;
   localparam int CODE_W = $clog2(N);
   localparam int DW     = $clog2(SCAN_DIV);
   localparam int CW     = $clog2(COLS);
   localparam int SW     = $clog2(DEB_FRAMES + 1);
   localparam int RW     = (REPEAT_FRAMES > 0) ?
                           $clog2(REPEAT_FRAMES + 1) : 1;

   typedef enum logic [1:0] {
      R_NONE,
      R_SINGLE,
      R_MULTI
   } res_e;

   typedef enum logic {
      IDLE,
      HELD
   } state_e;

   logic [DW-1:0]     div_cnt;
   logic [CW-1:0]     col_idx;
   logic [COLS-1:0]   scan_q;
   logic [ROWS-1:0]   row_snap [COLS];
   res_e              cand_kind;
   logic [CODE_W-1:0] cand_code;
   logic [SW-1:0]     stable_cnt;
   logic [RW-1:0]     rep_cnt;
   state_e            state;
   logic [CODE_W-1:0] code_q;
   logic              down_q;
   logic              valid_q;
   logic              rel_q;

   logic              tick;
   logic              frame_end;
   logic [N-1:0]      frame;
   logic [1:0]        hits;
   logic [CODE_W-1:0] res_code;
   res_e              res_kind;
   logic              match;
   logic [SW-1:0]     next_cnt;
   logic              accept;
   logic              same_held;

   assign tick      = (div_cnt == DW'(SCAN_DIV - 1));
   assign frame_end = tick && scan_q[0];

   // Last column is still being driven at frame end: use live rows.
   always_comb begin
      frame = '0;
      for (int c = 0; c < COLS; c++) begin
         for (int r = 0; r < ROWS; r++) begin
            frame[r*COLS+c] = (CW'(c) == col_idx) ?
                              kp.touch_key[ROWS-1-r] :
                              row_snap[c][ROWS-1-r];
         end
      end
   end

   always_comb begin
      hits     = 2'd0;
      res_code = '0;
      for (int i = 0; i < N; i++) begin
         if (frame[i]) begin
            if (hits != 2'd2) hits = hits + 2'd1;
            res_code = CODE_W'(i);
         end
      end
   end

   always_comb begin
      res_kind = R_NONE;
      if (hits == 2'd1) res_kind = R_SINGLE;
      if (hits == 2'd2) res_kind = R_MULTI;
   end

   assign match = (res_kind == cand_kind) &&
                  (res_kind != R_SINGLE || res_code == cand_code);

   always_comb begin
      next_cnt = SW'(1);
      if (match) begin
         next_cnt = (stable_cnt == SW'(DEB_FRAMES)) ?
                    stable_cnt : stable_cnt + SW'(1);
      end
   end

   assign accept = (next_cnt == SW'(DEB_FRAMES)) &&
                   !(match && stable_cnt == SW'(DEB_FRAMES));

   assign same_held = (res_kind == R_SINGLE) && (res_code == code_q);

   always_ff @(posedge fin) begin
      if (rst) begin
         div_cnt    <= '0;
         col_idx    <= '0;
         scan_q     <= {1'b1, {(COLS-1){1'b0}}};
         for (int c = 0; c < COLS; c++) row_snap[c] <= '0;
         cand_kind  <= R_NONE;
         cand_code  <= '0;
         stable_cnt <= '0;
         rep_cnt    <= '0;
         state      <= IDLE;
         code_q     <= '0;
         down_q     <= 1'b0;
         valid_q    <= 1'b0;
         rel_q      <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         rel_q   <= 1'b0;
         div_cnt <= tick ? '0 : div_cnt + DW'(1);
         if (tick) begin
            row_snap[col_idx] <= kp.touch_key;
            col_idx <= (col_idx == CW'(COLS - 1)) ?
                       '0 : col_idx + CW'(1);
            scan_q  <= {scan_q[0], scan_q[COLS-1:1]};
         end
         if (frame_end) begin
            cand_kind  <= res_kind;
            cand_code  <= res_code;
            stable_cnt <= next_cnt;
            unique case (state)
               IDLE: begin
                  if (accept && res_kind == R_SINGLE) begin
                     code_q  <= res_code;
                     down_q  <= 1'b1;
                     valid_q <= 1'b1;
                     rep_cnt <= '0;
                     state   <= HELD;
                  end
               end
               HELD: begin
                  if (accept && res_kind == R_SINGLE) begin
                     if (res_code != code_q) begin
                        code_q  <= res_code;
                        valid_q <= 1'b1;
                     end
                     rep_cnt <= '0;
                  end else if (accept && res_kind == R_NONE) begin
                     down_q <= 1'b0;
                     rel_q  <= 1'b1;
                     state  <= IDLE;
                  end else if (REPEAT_FRAMES > 0 && same_held) begin
                     if (rep_cnt == RW'(REPEAT_FRAMES - 1)) begin
                        rep_cnt <= '0;
                        valid_q <= 1'b1;
                     end else begin
                        rep_cnt <= rep_cnt + RW'(1);
                     end
                  end else begin
                     rep_cnt <= '0;
                  end
               end
            endcase
         end
      end
   end

   assign kp.scan_key    = scan_q;
   assign kp.key_code    = code_q;
   assign kp.key_down    = down_q;
   assign kp.key_valid   = valid_q;
   assign kp.key_release = rel_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a key-matrix model
// feeds two scanners (repeat off / repeat every 3 frames).
module tb_keypad_scan_ctrl;
   logic        fin = 1'b0;
   logic        rst;
   logic        rst2;
   logic [11:0] pressed;

   int total = 0;
   int bad   = 0;
   int vcnt1 = 0;
   int rcnt1 = 0;
   int both  = 0;

   always #5 fin = ~fin;

   keypad_scan_ctrl_if #(.ROWS(4), .COLS(3)) if1 ();
   keypad_scan_ctrl_if #(.ROWS(4), .COLS(3)) if2 ();

   keypad_scan_ctrl #(
      .COLS(3), .ROWS(4), .SCAN_DIV(4),
      .DEB_FRAMES(2), .REPEAT_FRAMES(0)
   ) dut1 (
      .fin(fin), .rst(rst), .kp(if1)
   );

   keypad_scan_ctrl #(
      .COLS(3), .ROWS(4), .SCAN_DIV(4),
      .DEB_FRAMES(2), .REPEAT_FRAMES(3)
   ) dut2 (
      .fin(fin), .rst(rst2), .kp(if2)
   );

   // Key k = row*3+col closes row r onto column c.
   function automatic logic [3:0] rows_of(
      input logic [11:0] p,
      input logic [2:0]  sk
   );
      logic [3:0] rw;
      rw = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (p[r*3+c] && sk[2-c]) rw[3-r] = 1'b1;
      return rw;
   endfunction

   assign if1.touch_key = rows_of(pressed, if1.scan_key);
   assign if2.touch_key = rows_of(pressed, if2.scan_key);

   always @(negedge fin) begin
      if (if1.key_valid) vcnt1++;
      if (if1.key_release) rcnt1++;
      if (if1.key_valid && if1.key_release) both++;
      if (if2.key_valid && if2.key_release) both++;
   end

   task automatic chk(input string nm, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   typedef struct {
      logic [11:0] keys;
      int          frames;
      int          n_valid;
      int          n_rel;
      int          code;
      int          down;
   } step_t;

   step_t tbl [18];

   initial begin
      int v0;
      int r0;
      bit ev;

      tbl[0]  = '{12'h001, 2, 1, 0, 0,  1};
      tbl[1]  = '{12'h000, 2, 0, 1, 0,  0};
      tbl[2]  = '{12'h010, 1, 0, 0, 0,  0};
      tbl[3]  = '{12'h000, 1, 0, 0, 0,  0};
      tbl[4]  = '{12'h010, 1, 0, 0, 0,  0};
      tbl[5]  = '{12'h000, 1, 0, 0, 0,  0};
      tbl[6]  = '{12'h010, 1, 0, 0, 0,  0};
      tbl[7]  = '{12'h010, 2, 1, 0, 4,  1};
      tbl[8]  = '{12'h000, 2, 0, 1, 4,  0};
      tbl[9]  = '{12'h101, 4, 0, 0, 4,  0};
      tbl[10] = '{12'h001, 2, 1, 0, 0,  1};
      tbl[11] = '{12'h101, 4, 0, 0, 0,  1};
      tbl[12] = '{12'h001, 2, 0, 0, 0,  1};
      tbl[13] = '{12'h800, 2, 1, 0, 11, 1};
      tbl[14] = '{12'h800, 6, 0, 0, 11, 1};
      tbl[15] = '{12'h000, 2, 0, 1, 11, 0};
      tbl[16] = '{12'h080, 2, 1, 0, 7,  1};
      tbl[17] = '{12'h000, 2, 0, 1, 7,  0};

      rst     = 1'b1;
      rst2    = 1'b1;
      pressed = '0;
      repeat (3) @(posedge fin);
      @(negedge fin);
      rst  = 1'b0;
      rst2 = 1'b0;
      #1;
      chk("rst_scan", int'(if1.scan_key), 3'b100);
      chk("rst_code", int'(if1.key_code), 0);
      chk("rst_down", int'(if1.key_down), 0);
      chk("rst_valid", int'(if1.key_valid), 0);
      chk("rst_release", int'(if1.key_release), 0);
      repeat (4) @(posedge fin);
      #1 chk("scan_col1", int'(if1.scan_key), 3'b010);
      repeat (4) @(posedge fin);
      #1 chk("scan_col2", int'(if1.scan_key), 3'b001);
      repeat (4) @(posedge fin);
      #1 chk("scan_wrap", int'(if1.scan_key), 3'b100);
      @(negedge fin);

      for (int i = 0; i < 18; i++) begin
         pressed = tbl[i].keys;
         v0 = vcnt1;
         r0 = rcnt1;
         repeat (tbl[i].frames * 12) @(posedge fin);
         @(negedge fin);
         #1;
         chk($sformatf("step%0d_valid", i), vcnt1 - v0, tbl[i].n_valid);
         chk($sformatf("step%0d_rel", i), rcnt1 - r0, tbl[i].n_rel);
         chk($sformatf("step%0d_code", i),
             int'(if1.key_code), tbl[i].code);
         chk($sformatf("step%0d_down", i),
             int'(if1.key_down), tbl[i].down);
      end

      pressed = '0;
      rst2 = 1'b1;
      @(posedge fin);
      @(negedge fin);
      rst2 = 1'b0;
      pressed = 12'h020;
      for (int f = 1; f <= 11; f++) begin
         repeat (12) @(posedge fin);
         @(negedge fin);
         #1;
         ev = (f == 2 || f == 5 || f == 8 || f == 11);
         chk($sformatf("rep_frame%0d", f), int'(if2.key_valid), int'(ev));
         if (f == 2) chk("rep_code", int'(if2.key_code), 5);
      end

      repeat (5) @(posedge fin);
      @(negedge fin);
      rst2 = 1'b1;
      @(posedge fin);
      #1;
      chk("midrst_scan", int'(if2.scan_key), 3'b100);
      chk("midrst_code", int'(if2.key_code), 0);
      chk("midrst_down", int'(if2.key_down), 0);
      chk("midrst_valid", int'(if2.key_valid), 0);
      chk("midrst_release", int'(if2.key_release), 0);
      @(negedge fin);
      rst2 = 1'b0;
      pressed = '0;

      chk("no_overlap", both, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
